// File: rtl/hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO sequencer: op codes, FSM states, defaults.
// No logic; constants and types only.
// Imported by the controller and its bench.
package hilo_ctrl_pkg;

  localparam int TIMEOUT_DEF = 40;  // divider needs 32 cycles plus margin
  localparam int W_DEF       = 32;

  // Op encoding from the control unit; codes 5-7 fall through as NONE
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DIV  = 3'd1,
    OP_MULT = 3'd2,
    OP_MTHI = 3'd3,
    OP_MTLO = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_DIV_LAUNCH  = 3'd1,
    S_DIV_WAIT    = 3'd2,
    S_MULT_LAUNCH = 3'd3,
    S_MULT_WAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/hilo_ctrl_if.sv
// CPU-side request/result bundle for the HI/LO sequencer.
// Latency: n/a (wires only).
// Backpressure: op_ready low holds the request at the caller.
interface hilo_ctrl_if #(
  parameter int W = 32
);
  logic         op_valid;
  logic [2:0]   op;
  logic [W-1:0] rs_data;
  logic         op_ready;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div0_exc;
  logic         tmo_exc;

  // Control unit side
  modport master (
    output op_valid, op, rs_data,
    input  op_ready, busy, hi, lo, div0_exc, tmo_exc
  );

  // Sequencer side
  modport slave (
    input  op_valid, op, rs_data,
    output op_ready, busy, hi, lo, div0_exc, tmo_exc
  );
endinterface

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
// Latency: written value visible the cycle after the enable.
// Backpressure: none; writes always take effect.
module hilo_reg #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_hi_we,
  input  logic         i_lo_we,
  input  logic [W-1:0] i_hi_d,
  input  logic [W-1:0] i_lo_d,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;

  // Synchronous clear, otherwise load each half on its own enable
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_hi_we) r_hi <= i_hi_d;
      if (i_lo_we) r_lo <= i_lo_d;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/hilo_ctrl.sv
// Sequences DIV/MULT/MTHI/MTLO into the iterative units and owns HI/LO.
// Latency: MTHI/MTLO 1 cycle; DIV/MULT = launch cycle + unit time, result next cycle.
// Backpressure: op_ready low while a unit op is in flight; caller holds request.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int W       = W_DEF
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  hilo_ctrl_if.slave   bus,
  output logic         o_div_rst,
  output logic         o_div_start,
  input  logic         i_div_done,
  input  logic         i_div_zero,
  input  logic [W-1:0] i_div_hi,
  input  logic [W-1:0] i_div_lo,
  output logic         o_mult_start,
  input  logic         i_mult_done,
  input  logic [W-1:0] i_mult_hi,
  input  logic [W-1:0] i_mult_lo
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        r_state;
  state_e        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_hi_we;
  logic          w_lo_we;
  logic [W-1:0]  w_hi_d;
  logic [W-1:0]  w_lo_d;
  logic          w_div_start;
  logic          w_mult_start;
  logic          w_div0;
  logic          w_tmo;

  // State and wait counter; reset mid-op simply drops the operation
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state, unit launches, HI/LO writes and exception pulses
  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_hi_we      = 1'b0;
    w_lo_we      = 1'b0;
    w_hi_d       = bus.rs_data;
    w_lo_d       = bus.rs_data;
    w_div_start  = 1'b0;
    w_mult_start = 1'b0;
    w_div0       = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (bus.op)
            OP_DIV:  w_next  = S_DIV_LAUNCH;
            OP_MULT: w_next  = S_MULT_LAUNCH;
            OP_MTHI: w_hi_we = 1'b1;
            OP_MTLO: w_lo_we = 1'b1;
            default: ;
          endcase
        end
      end
      S_DIV_LAUNCH: begin
        w_div_start = 1'b1;
        w_cnt_next  = '0;
        w_next      = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        // Zero beats done (done never fires on /0); done beats timeout
        if (i_div_zero) begin
          w_div0 = 1'b1;
          w_next = S_IDLE;
        end else if (i_div_done) begin
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = i_div_hi;
          w_lo_d  = i_div_lo;
          w_next  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_MULT_LAUNCH: begin
        w_mult_start = 1'b1;
        w_cnt_next   = '0;
        w_next       = S_MULT_WAIT;
      end
      S_MULT_WAIT: begin
        if (i_mult_done) begin
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = i_mult_hi;
          w_lo_d  = i_mult_lo;
          w_next  = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  hilo_reg #(.W(W)) u_hilo_reg (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_hi_we   (w_hi_we),
    .i_lo_we   (w_lo_we),
    .i_hi_d    (w_hi_d),
    .i_lo_d    (w_lo_d),
    .o_hi      (bus.hi),
    .o_lo      (bus.lo)
  );

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.op_ready = (r_state == S_IDLE);
  assign bus.div0_exc = w_div0;
  assign bus.tmo_exc  = w_tmo;
  assign o_div_start  = w_div_start;
  assign o_mult_start = w_mult_start;
  // The divider resets on a high level
  assign o_div_rst    = ~i_reset_n;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: IDLE-state vector table plus unit-op sequences.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        div_rst, div_start, div_done, div_zero;
  logic        mult_start, mult_done;
  logic [31:0] div_hi, div_lo, mult_hi, mult_lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_ctrl_if #(.W(32)) bus();

  hilo_ctrl #(.TIMEOUT(40), .W(32)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .bus          (bus),
    .o_div_rst    (div_rst),
    .o_div_start  (div_start),
    .i_div_done   (div_done),
    .i_div_zero   (div_zero),
    .i_div_hi     (div_hi),
    .i_div_lo     (div_lo),
    .o_mult_start (mult_start),
    .i_mult_done  (mult_done),
    .i_mult_hi    (mult_hi),
    .i_mult_lo    (mult_lo)
  );

  typedef struct {
    logic        vld;
    logic [2:0]  op;
    logic [31:0] rs;
    logic        dd;
    logic        dz;
    logic        md;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a DIV/MULT and play the unit: done (or zero) in wait cycle done_at (0 = never)
  task automatic run_unit(input logic [2:0] op, input int done_at, input logic zero,
                          output int nbusy, output int nds, output int nms,
                          output int nd0, output int ntmo, output int exc_idx);
    int widx;
    bit inw;
    bit fin;
    nbusy = 0; nds = 0; nms = 0; nd0 = 0; ntmo = 0; exc_idx = -1;
    widx = 0; inw = 1'b0; fin = 1'b0;
    bus.op_valid = 1'b1;
    bus.op       = op;
    tick();
    bus.op_valid = 1'b0;
    bus.op       = OP_NONE;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (bus.busy) nbusy++;
      if (div_start) nds++;
      if (mult_start) nms++;
      if (div_start || mult_start) begin
        inw  = 1'b1;
        widx = 0;
      end else if (inw) begin
        widx++;
      end
      div_done  = (op == OP_DIV) && !zero && (done_at != 0) && (widx == done_at);
      div_zero  = (op == OP_DIV) && zero && (widx == done_at);
      mult_done = (op == OP_MULT) && (done_at != 0) && (widx == done_at);
      #1;
      if (bus.div0_exc) begin nd0++;  exc_idx = widx; end
      if (bus.tmo_exc)  begin ntmo++; exc_idx = widx; end
      if (!bus.busy) fin = 1'b1;
      else tick();
    end
    div_done  = 1'b0;
    div_zero  = 1'b0;
    mult_done = 1'b0;
    check("op_returns_to_idle", {31'd0, fin}, 32'd1);
  endtask

  initial begin
    int nb, nds, nms, nd0, ntmo, eidx;

    vecs[0] = '{1'b1, OP_MTHI, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0};
    vecs[1] = '{1'b1, OP_MTLO, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[2] = '{1'b0, OP_MTHI, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[3] = '{1'b1, 3'd5,    32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[4] = '{1'b1, 3'd7,    32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[5] = '{1'b1, OP_NONE, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_5678};
    vecs[6] = '{1'b1, OP_NONE, 32'h0000_BEEF, 1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h0000_5678};
    vecs[7] = '{1'b1, OP_MTHI, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h0000_5678};
    vecs[8] = '{1'b1, OP_MTLO, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A};

    bus.op_valid = 1'b0; bus.op = OP_NONE; bus.rs_data = '0;
    div_done = 1'b0; div_zero = 1'b0; mult_done = 1'b0;
    div_hi = 32'hD1D1_0001; div_lo = 32'hD1D1_0002;
    mult_hi = 32'hEEEE_0001; mult_lo = 32'hEEEE_0002;

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    check("rst_div_rst", {31'd0, div_rst}, 32'd1);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    check("rst_starts", {30'd0, div_start, mult_start}, 32'd0);
    check("rst_exc", {30'd0, bus.div0_exc, bus.tmo_exc}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("run_div_rst", {31'd0, div_rst}, 32'd0);

    // IDLE vectors: MTHI/MTLO back-to-back, ignored ops, stray done/zero in IDLE
    for (int i = 0; i < 9; i++) begin
      bus.op_valid = vecs[i].vld;
      bus.op       = vecs[i].op;
      bus.rs_data  = vecs[i].rs;
      div_done     = vecs[i].dd;
      div_zero     = vecs[i].dz;
      mult_done    = vecs[i].md;
      tick();
      check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].ehi);
      check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].elo);
      check($sformatf("vec%0d_busy", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("vec%0d_exc_start", i),
            {28'd0, bus.div0_exc, bus.tmo_exc, div_start, mult_start}, 32'd0);
    end
    bus.op_valid = 1'b0; bus.op = OP_NONE;
    div_done = 1'b0; div_zero = 1'b0; mult_done = 1'b0;
    tick();

    // DIV by zero: single div0_exc, HI/LO untouched
    run_unit(OP_DIV, 1, 1'b1, nb, nds, nms, nd0, ntmo, eidx);
    check("dz_busy_cycles", nb, 2);
    check("dz_div_start", nds, 1);
    check("dz_div0_pulses", nd0, 1);
    check("dz_exc_wait_idx", eidx, 1);
    check("dz_tmo", ntmo, 0);
    check("dz_hi", bus.hi, 32'hA5A5_A5A5);
    check("dz_lo", bus.lo, 32'h5A5A_5A5A);
    tick();
    check("dz_exc_gone", {31'd0, bus.div0_exc}, 32'd0);

    // DIV normal: done in wait cycle 33 -> busy 34 cycles
    div_hi = 32'd1; div_lo = 32'd3;
    run_unit(OP_DIV, 33, 1'b0, nb, nds, nms, nd0, ntmo, eidx);
    check("div_busy_cycles", nb, 34);
    check("div_start_pulses", nds, 1);
    check("div_mult_start", nms, 0);
    check("div_exc", nd0 + ntmo, 0);
    check("div_hi", bus.hi, 32'd1);
    check("div_lo", bus.lo, 32'd3);
    check("div_ready", {31'd0, bus.op_ready}, 32'd1);

    // MULT: done after 5 wait cycles
    mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFFE;
    run_unit(OP_MULT, 5, 1'b0, nb, nds, nms, nd0, ntmo, eidx);
    check("mul_busy_cycles", nb, 6);
    check("mul_start_pulses", nms, 1);
    check("mul_no_div_start", nds, 0);
    check("mul_hi", bus.hi, 32'hFFFF_FFFF);
    check("mul_lo", bus.lo, 32'hFFFF_FFFE);

    // DIV timeout: no done, tmo_exc in wait cycle 40
    run_unit(OP_DIV, 0, 1'b0, nb, nds, nms, nd0, ntmo, eidx);
    check("tmo_busy_cycles", nb, 41);
    check("tmo_pulses", ntmo, 1);
    check("tmo_wait_idx", eidx, 40);
    check("tmo_no_div0", nd0, 0);
    check("tmo_hi", bus.hi, 32'hFFFF_FFFF);
    check("tmo_lo", bus.lo, 32'hFFFF_FFFE);
    tick();
    check("tmo_exc_gone", {31'd0, bus.tmo_exc}, 32'd0);

    // MULT done in the same cycle the timeout would fire: done wins
    mult_hi = 32'h1111_1111; mult_lo = 32'h2222_2222;
    run_unit(OP_MULT, 40, 1'b0, nb, nds, nms, nd0, ntmo, eidx);
    check("dwin_busy_cycles", nb, 41);
    check("dwin_no_tmo", ntmo, 0);
    check("dwin_hi", bus.hi, 32'h1111_1111);
    check("dwin_lo", bus.lo, 32'h2222_2222);

    // MTHI held while busy is not taken until the MULT completes
    bus.op_valid = 1'b1; bus.op = OP_MULT;
    tick();
    bus.op = OP_MTHI; bus.rs_data = 32'h0000_CAFE;
    tick();
    check("hold_ready", {31'd0, bus.op_ready}, 32'd0);
    tick();
    check("hold_hi_kept", bus.hi, 32'h1111_1111);
    mult_hi = 32'h3333_3333; mult_lo = 32'h4444_4444; mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("hold_mul_hi", bus.hi, 32'h3333_3333);
    check("hold_ready_back", {31'd0, bus.op_ready}, 32'd1);
    tick();
    bus.op_valid = 1'b0; bus.op = OP_NONE;
    check("hold_mthi_hi", bus.hi, 32'h0000_CAFE);
    check("hold_mthi_lo", bus.lo, 32'h4444_4444);
    check("hold_busy", {31'd0, bus.busy}, 32'd0);

    // Reset during DIV_WAIT aborts silently; a late done is ignored
    bus.op_valid = 1'b1; bus.op = OP_DIV;
    tick();
    bus.op_valid = 1'b0; bus.op = OP_NONE;
    tick(); tick();
    check("mid_busy_before", {31'd0, bus.busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_div_rst", {31'd0, div_rst}, 32'd1);
    tick();
    reset_n = 1'b1;
    check("mid_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_hi", bus.hi, 32'h0);
    check("mid_lo", bus.lo, 32'h0);
    check("mid_exc", {30'd0, bus.div0_exc, bus.tmo_exc}, 32'd0);
    div_hi = 32'h7777_7777; div_lo = 32'h8888_8888; div_done = 1'b1;
    #1;
    check("late_exc", {30'd0, bus.div0_exc, bus.tmo_exc}, 32'd0);
    tick();
    div_done = 1'b0;
    check("late_hi", bus.hi, 32'h0);
    check("late_lo", bus.lo, 32'h0);
    check("late_busy", {31'd0, bus.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
